full_adder: RTL and testbench
=============================

# full_adder

Parameterizable ripple-carry adder built from single-bit full-adder cells. At the default `WIDTH = 1` it is a plain full adder:
- `sum = a ^ b ^ cin`
- `cout = majority(a, b, cin)`

It provides a combinational result path for glue logic and a registered, valid-qualified copy for pipelined datapaths. The block is a leaf arithmetic primitive, instantiated wherever a small adder with carry-in/carry-out is needed.

## Interface
Parameters:
- `WIDTH`, default 1: operand and sum width in bits; legal range 1–64.

Ports:
- `clk`, input, 1: single clock, rising-edge active.
- `rst`, input, 1: reset; asynchronous, active-high.
- `a`, input, WIDTH: operand A, unsigned.
- `b`, input, WIDTH: operand B, unsigned.
- `cin`, input, 1: carry-in, weight 1.
- `in_valid`, input, 1: qualifies `a`, `b` and `cin` for the registered path.
- `sum`, output, WIDTH: combinational sum, low WIDTH bits of `a + b + cin`.
- `cout`, output, 1: combinational carry-out, bit WIDTH of `a + b + cin`.
- `sum_q`, output, WIDTH: registered `sum`.
- `cout_q`, output, 1: registered `cout`.
- `out_valid`, output, 1: `sum_q` and `cout_q` hold a valid result.

## Operation
- Arithmetic: `{cout, sum} = a + b + cin`, computed at WIDTH+1 bits.
  - No overflow is possible.
  - The carry out of the MSB is exactly `cout`.
  - `WIDTH = 1` gives the 8-row full-adder truth table.
- Carry chain: bit i computes `s[i] = a[i] ^ b[i] ^ c[i]` and `c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))`.
  - `c[0] = cin`.
  - `cout = c[WIDTH]`.
- Combinational path (`sum`, `cout`):
  - Independent of `clk`, `rst` and `in_valid`.
  - Always reflects the current inputs.
- Registered path:
  - On each rising `clk` with `in_valid = 1`: `sum_q` and `cout_q` load `sum` and `cout`, and `out_valid` is set to 1.
  - On a rising `clk` with `in_valid = 0`: `sum_q` and `cout_q` hold their value, and `out_valid` is set to 0.
- Reset:
  - While `rst = 1`: `sum_q = 0`, `cout_q = 0`, `out_valid = 0`, immediately and independent of `clk`.
  - Combinational outputs are unaffected by reset.
- X-propagation: any X/Z input bit may produce X on the dependent outputs. No masking is required.

## Timing
- Combinational path: zero-cycle latency.
  - Outputs settle within one ripple of WIDTH cells after any input change.
  - The critical path is `cin` to `cout` through WIDTH cells.
- Registered path: 1-cycle latency. A result sampled at edge N appears on `sum_q`, `cout_q` and `out_valid` after edge N.
- Throughput: one result per cycle. No backpressure and no handshake beyond `in_valid`.
- Reset assertion mid-stream: registered outputs clear asynchronously, and any in-flight sample is dropped.
- First clock edge after `rst` deasserts: behaves as a normal edge, so `in_valid = 1` on that edge loads a result.
- Inputs changing between edges have no effect on registered outputs until the next edge.

## Structure
- Sub-module `full_adder_bit`: ports `a`, `b`, `cin`, `sum`, `cout`, all 1 bit, purely combinational. `full_adder` instantiates it WIDTH times in a generate loop.
- No shared package is needed.
  - `WIDTH` is local to the block.
  - The reset value 0 for registered outputs is a local constant.
- All state (`sum_q`, `cout_q`, `out_valid`) lives in a single always block with asynchronous `rst` in the sensitivity list.

## Test plan
1. **Exhaustive combinational check**, `WIDTH = 1`. Apply all 8 `(a, b, cin)` in binary order, 100 ns apart. Required `{cout, sum}`:
   - 000 → 00
   - 001 → 01
   - 010 → 01
   - 011 → 10
   - 100 → 01
   - 101 → 10
   - 110 → 10
   - 111 → 11
2. **Full carry ripple**, `WIDTH = 8`:
   - `a = 0xFF`, `b = 0x00`, `cin = 1` → `sum = 0x00`, `cout = 1`.
   - `a = 0x7F`, `b = 0x01`, `cin = 0` → `sum = 0x80`, `cout = 0`.
3. **Registered path**, `WIDTH = 8`. With `in_valid = 1`, apply `a = 0x12`, `b = 0x34`, `cin = 1` at edge N → after edge N, `sum_q = 0x47`, `cout_q = 0`, `out_valid = 1`.
4. **Hold on invalid**. After scenario 3, change `a` to `0xFF` with `in_valid = 0` → after the next edge:
   - `sum_q` still `0x47`.
   - `out_valid = 0`.
   - Combinational `sum` shows the new value.
5. **Asynchronous reset mid-stream**. Assert `rst` between clock edges while `out_valid = 1`:
   - Registered outputs go to 0 before the next edge.
   - Combinational `sum` and `cout` stay correct throughout.
6. **Randomized check**, `WIDTH = 16`. Apply 1000 random `(a, b, cin)` with `in_valid` toggling randomly → `{cout, sum}` and the one-cycle-delayed `{cout_q, sum_q}` match a reference `a + b + cin` every time.

Source files
------------

// File: rtl/full_adder_bit.sv
// Purpose : single-bit full-adder cell, the ripple element of full_adder.
// Latency : purely combinational, zero cycles.
// Backpressure: none; no handshake of any kind.
//
// Ports:
//   a, b  - operand bits
//   cin   - carry into this bit position
//   sum   - a ^ b ^ cin
//   cout  - carry out of this bit position (majority of a, b, cin)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // The propagate term is shared by the sum and the carry.
  logic w_prop;

  assign w_prop = a ^ b;
  assign sum    = w_prop ^ cin;
  // Generate when both operand bits are set; otherwise propagate the incoming carry.
  assign cout   = (a & b) | (cin & w_prop);

endmodule

// File: rtl/full_adder.sv
// Purpose : WIDTH-bit ripple-carry adder with a combinational result and a
//           registered, valid-qualified copy of the same result.
// Latency : sum/cout zero cycles; sum_q/cout_q/out_valid one cycle.
// Backpressure: none; one result per cycle, qualified only by in_valid.
//
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-high reset
//   a, b             - unsigned WIDTH-bit operands
//   cin              - carry-in (weight 1)
//   in_valid         - qualifies a/b/cin for the registered path
//   sum, cout        - combinational {cout, sum} = a + b + cin
//   sum_q, cout_q    - registered sum/cout, held while in_valid is low
//   out_valid        - sum_q/cout_q were loaded on the most recent edge
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] RST_SUM = '0;

  // Carry chain: w_carry[0] is the external carry-in, w_carry[WIDTH] is cout.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic             r_out_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .sum  (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  assign sum  = w_sum;
  assign cout = w_carry[WIDTH];

  // Result registers load only on a valid edge, while the valid flag
  // tracks in_valid every edge so a stale held result is never flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_q     <= RST_SUM;
      r_cout_q    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q  <= w_sum;
        r_cout_q <= w_carry[WIDTH];
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign cout_q    = r_cout_q;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_full_adder.sv
// Purpose : self-checking bench for full_adder at WIDTH 1, 8 and 16.
// Latency : checks comb outputs 1 ns after input change, registered 1 ns after posedge.
// Backpressure: not applicable; stimulus is free-running.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;

  // WIDTH = 1 instance
  logic       a1, b1, cin1, v1;
  logic       s1, c1, sq1, cq1, ov1;
  // WIDTH = 8 instance
  logic [7:0] a8, b8;
  logic       cin8, v8;
  logic [7:0] s8, sq8;
  logic       c8, cq8, ov8;
  // WIDTH = 16 instance
  logic [15:0] a16, b16;
  logic        cin16, v16;
  logic [15:0] s16, sq16;
  logic        c16, cq16, ov16;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(v1),
    .sum(s1), .cout(c1), .sum_q(sq1), .cout_q(cq1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
    .sum(s8), .cout(c8), .sum_q(sq8), .cout_q(cq8), .out_valid(ov8)
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .in_valid(v16),
    .sum(s16), .cout(c16), .sum_q(sq16), .cout_q(cq16), .out_valid(ov16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-adder truth table in (a,b,cin) binary order, as {cout,sum}.
  logic [1:0] tt [8];

  logic [16:0] ref16;
  logic [16:0] exp_q16;
  logic        exp_v16;

  initial begin
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0; v1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; v8 = 0;
    a16 = 0; b16 = 0; cin16 = 0; v16 = 0;
    #2;

    // Reset state of all registered outputs.
    check("rst_w1_q",  64'({cq1, sq1, ov1}), 64'(0));
    check("rst_w8_q",  64'({cq8, sq8, ov8}), 64'(0));
    check("rst_w16_q", 64'({cq16, sq16, ov16}), 64'(0));

    @(negedge clk);
    rst = 1'b0;

    // 1. Exhaustive WIDTH=1 truth table, 100 ns per row.
    for (int i = 0; i < 8; i++) begin
      a1   = i[2];
      b1   = i[1];
      cin1 = i[0];
      #1;
      check($sformatf("tt_row%0d", i), 64'({c1, s1}), 64'(tt[i]));
      #99;
    end

    // 2. Full carry ripple at WIDTH=8.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    #1;
    check("ripple_ff_sum",  64'(s8), 64'(8'h00));
    check("ripple_ff_cout", 64'(c8), 64'(1'b1));
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    #1;
    check("ripple_7f_sum",  64'(s8), 64'(8'h80));
    check("ripple_7f_cout", 64'(c8), 64'(1'b0));

    // 3. Registered path load.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; v8 = 1'b1;
    @(posedge clk);
    #1;
    check("reg_sum_q",  64'(sq8),  64'(8'h47));
    check("reg_cout_q", 64'(cq8),  64'(1'b0));
    check("reg_valid",  64'(ov8),  64'(1'b1));

    // 4. Hold on invalid; comb path shows new operand immediately.
    @(negedge clk);
    a8 = 8'hFF; v8 = 1'b0;
    #1;
    check("hold_comb_sum",  64'(s8), 64'(8'h34));
    check("hold_comb_cout", 64'(c8), 64'(1'b1));
    check("hold_q_pre_edge", 64'(sq8), 64'(8'h47));
    @(posedge clk);
    #1;
    check("hold_sum_q",  64'(sq8), 64'(8'h47));
    check("hold_cout_q", 64'(cq8), 64'(1'b0));
    check("hold_valid",  64'(ov8), 64'(1'b0));

    // 5. Asynchronous reset between edges while out_valid is high.
    @(negedge clk);
    a8 = 8'h12; v8 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(ov8), 64'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_sum_q",  64'(sq8), 64'(0));
    check("arst_cout_q", 64'(cq8), 64'(0));
    check("arst_valid",  64'(ov8), 64'(0));
    check("arst_comb",   64'({c8, s8}), 64'(9'h047));
    @(posedge clk);
    #1;
    check("rst_edge_valid", 64'(ov8), 64'(0));
    check("rst_edge_comb",  64'({c8, s8}), 64'(9'h047));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_sum_q", 64'(sq8), 64'(8'h47));
    check("post_rst_valid", 64'(ov8), 64'(1'b1));

    // 6. Randomized WIDTH=16 against arithmetic model.
    exp_q16 = '0;
    exp_v16 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom_range(0, 1));
      v16   = 1'($urandom_range(0, 1));
      #1;
      ref16 = 17'(a16) + 17'(b16) + 17'(cin16);
      check("rand_comb_sum",  64'(s16), 64'(ref16[15:0]));
      check("rand_comb_cout", 64'(c16), 64'(ref16[16]));
      @(posedge clk);
      if (v16) begin
        exp_q16 = ref16;
        exp_v16 = 1'b1;
      end else begin
        exp_v16 = 1'b0;
      end
      #1;
      check("rand_sum_q",  64'(sq16), 64'(exp_q16[15:0]));
      check("rand_cout_q", 64'(cq16), 64'(exp_q16[16]));
      check("rand_valid",  64'(ov16), 64'(exp_v16));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
